pipe_stage_array: RTL and testbench
===================================

Name: pipe_stage_array

Overview:
- Parametrised elastic register pipeline: LANES parallel lanes of WIDTH bits, carried through DEPTH register stages with a valid/ready handshake.
- Next-generation multi-stage register fixture for scan-chain and hierarchy tests.
- Each stage is a separate sub-instance, so the registers sit at nested hierarchy depth, with flush, backpressure and occupancy tracking.
- Used as a design-under-test for the scan insertion passes and as a reusable pipeline in the codebase.

Parameters:
- WIDTH, 4, bits per lane.
- LANES, 2, number of parallel lanes; the data bus is LANES*WIDTH bits.
- DEPTH, 3, number of register stages; minimum 1.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipeline accepts in_data this cycle.
- in_data  input  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  LANES*WIDTH  last-stage data.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages, range 0..DEPTH.
- stall_cnt  output  16  stall statistics; only meaningful with the optional feature.

Behaviour:
- Reset (rst=1 at an edge): all stage valid bits 0, all stage data 0, occupancy 0, stall_cnt 0.
  - Outputs during and after reset: out_valid=0, out_data=0, in_ready=1 once rst=0 and flush=0.
  - Reset mid-stream discards all in-flight data; nothing is emitted afterwards.
- Stage i holds v[i] and d[i]. Stage DEPTH-1 drives out_valid and out_data.
- Move conditions (combinational, computed from the last stage backwards):
  - mv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - Stage i can load when !v[i] or mv[i].
  - mv[i] = v[i] & (stage i+1 can load).
- in_ready = (!v[0] | mv[0]) & !flush & !rst.
- Stage update on an edge:
  - Stage i loads from stage i-1 (or from in_data for i=0) when the upstream move or accept is true. It then takes v=1 and the upstream data.
  - If stage i moves out with nothing arriving, v[i] becomes 0.
  - Data registers never change when their stage does not load. Stale data is retained while v=0.
- Throughput and latency:
  - Full throughput: one word per cycle when out_ready=1 continuously.
  - Latency: a word accepted at edge n appears as out_valid=1 after edge n+DEPTH-1, i.e. DEPTH register stages with no bypass.
- Bubbles collapse: an invalid stage accepts from upstream even while downstream is stalled.
- Flush (flush=1 at an edge): all v become 0; in_ready=0 that cycle, so no input is accepted.
  - out_valid and out_data are still visible in the flush cycle.
  - If out_ready=1 during flush, the downstream consumer may take that word. The pipeline treats it as consumed, and it is not re-emitted.
- occupancy: registered, equal to the popcount of v after each edge; 0 after reset or flush.
  - Accept and emit in the same cycle leave it unchanged.
  - At occupancy==DEPTH with out_ready=0, in_ready=0 (full).
  - At occupancy==DEPTH with out_ready=1, in_ready=1 (pass-through while full).
- Empty pipeline: out_valid=0, and out_ready has no effect.
- Priority order: rst > flush > normal handshake.
- Lanes are independent bit-slices that share one valid/ready. Data is never modified in flight.

Optional Feature:
- Macro: PIPE_STALL_STATS_EN.
- Defined: stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst only, not by flush.
- Undefined: stall_cnt tied to 16'h0000, with no counter flops generated. Pipeline behaviour is identical in both builds.

Test Plan:
- Reset then stream, with DEPTH=3, LANES=2, WIDTH=4 and out_ready=1:
  - Stimulus: in_data 8'h21, 8'h43, 8'h65 on consecutive cycles.
  - Required: out_data 8'h21, 8'h43, 8'h65 with out_valid first asserted 2 cycles after the 8'h21 accept. occupancy peaks at 3.
- Backpressure: out_ready=0 while in_valid=1 streams 8'hA1, 8'hA2, 8'hA3, 8'hA4.
  - Required: after 3 accepts, in_ready=0 and occupancy=3.
  - Then out_ready=1: out_data is 8'hA1, then 8'hA2, then 8'hA3, with in_ready=1 in those cycles. 8'hA4 follows; no word is lost or duplicated.
- Bubble collapse: accept 8'h11, idle one cycle, accept 8'h22, out_ready=0.
  - Required: both words occupy the last two stages and occupancy=2.
- Flush with occupancy=3: pulse flush with in_valid=1 and in_data=8'hFF.
  - Required: in_ready=0 in the flush cycle; the next cycle gives occupancy=0 and out_valid=0. 8'hFF never appears at the output.
- Reset mid-operation: assert rst at occupancy=2.
  - Required: next cycle out_valid=0, out_data=0, occupancy=0, stall_cnt=0.
  - Subsequent stream 8'h5A emerges normally.
- PIPE_STALL_STATS_EN:
  - Defined: hold out_valid=1 with out_ready=0 for 10 cycles; required stall_cnt=10, unchanged by a following flush.
  - Undefined: stall_cnt stays 0 under the same stimulus.

Source files
------------

// File: rtl/pipe_stage_array.sv
// pipe_stage_array: elastic register pipeline, LANES x WIDTH bits wide, DEPTH
// stages deep, valid/ready handshake on both ends. Each stage is its own
// pipe_stage_reg instance so the flops sit one level down in the hierarchy.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous clear of every stage valid bit
//   in_valid/ready  upstream handshake, in_data lane k at [k*WIDTH +: WIDTH]
//   out_valid/ready downstream handshake, out_data from the last stage
//   occupancy       registered count of valid stages (0..DEPTH)
//   stall_cnt       cycles with out_valid & !out_ready, saturating
//
// Optional feature macro: PIPE_STALL_STATS_EN. When undefined, stall_cnt is
// tied to zero and no counter flops exist; pipeline behaviour is unchanged.

module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] din,
    output logic         vld,
    output logic [W-1:0] dat
);
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= '0;
        end else begin
            if (flush)       vld <= 1'b0;
            else if (load)   vld <= 1'b1;
            else if (unload) vld <= 1'b0;
            // data only moves on a load; stale contents stay while vld=0
            if (load) dat <= din;
        end
    end
endmodule

module pipe_stage_array #(
    parameter int WIDTH = 4,
    parameter int LANES = 2,
    parameter int DEPTH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*WIDTH-1:0]      in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy,
    output logic [15:0]                 stall_cnt
);
    localparam int BUS   = LANES * WIDTH;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic           v  [DEPTH];
    logic [BUS-1:0] d  [DEPTH];
    logic           mv [DEPTH];
    logic           ld [DEPTH];

    // Move chain resolved from the output backwards: a stage moves when it is
    // valid and the stage after it has room (empty or itself moving).
    always_comb begin
        logic room;
        room = out_ready;
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            mv[i] = v[i] & room;
            room  = !v[i] | mv[i];
        end
        in_ready = room & !flush & !rst;
    end

    // Loads are suppressed during flush so data registers stay put.
    always_comb begin
        ld[0] = in_valid & in_ready;
        for (int i = 1; i < DEPTH; i++) ld[i] = mv[i-1] & !flush;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pipe_stage_reg #(.W(BUS)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush),
            .load   (ld[i]),
            .unload (mv[i]),
            .din    ((i == 0) ? in_data : d[(i == 0) ? 0 : i-1]),
            .vld    (v[i]),
            .dat    (d[i])
        );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // Occupancy tracks accepts minus emits instead of re-counting v bits.
    always_ff @(posedge clk) begin
        if (rst || flush) occupancy <= '0;
        else occupancy <= occupancy + OCC_W'(ld[0]) - OCC_W'(mv[DEPTH-1]);
    end

`ifdef PIPE_STALL_STATS_EN
    // Cleared by rst only; flush leaves the statistics alone.
    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_array.sv
// Scoreboard bench for pipe_stage_array (DEPTH=3, LANES=2, WIDTH=4).
// Accepted words are queued at the negedge handshake sample and popped and
// compared whenever the DUT emits.

module tb_pipe_stage_array;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [7:0]  in_data, out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic [7:0]  sb[$];
    int          total = 0;
    int          bad = 0;
    int          emitted = 0;
    int          e0;

`ifdef PIPE_STALL_STATS_EN
    localparam logic [15:0] EXP_STALL = 16'd10;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    always #5 clk = ~clk;

    pipe_stage_array #(.WIDTH(4), .LANES(2), .DEPTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then step past the rising edge.
    task automatic cyc();
        @(negedge clk);
        if (!rst) begin
            if (out_valid && out_ready) begin
                chk("emit_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) chk("out_data", out_data, sb.pop_front());
                emitted++;
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            if (flush) sb.delete();
        end else begin
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 20 && !acc; k++) begin
            #1;
            acc = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        chk("send_accept", 32'(acc), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = 8'h00;

        // reset state
        cyc(); cyc();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // stream with latency check: out_valid after edge n+2
        send(8'h21); chk("lat_e0", 32'(out_valid), 0);
        send(8'h43); chk("lat_e1", 32'(out_valid), 0);
        send(8'h65); chk("lat_e2", 32'(out_valid), 1);
        chk("stream_occ_peak", occupancy, 3);
        idle(5);
        chk("stream_drained", 32'(sb.size()), 0);
        chk("stream_occ_end", occupancy, 0);

        // backpressure
        out_ready = 1'b0;
        e0 = emitted;
        send(8'hA1); send(8'hA2); send(8'hA3);
        in_valid = 1'b1; in_data = 8'hA4;
        #1;
        chk("bp_full_in_ready", 32'(in_ready), 0);
        chk("bp_full_occ", occupancy, 3);
        cyc();
        out_ready = 1'b1;
        #1;
        chk("bp_passthru_in_ready", 32'(in_ready), 1);
        chk("bp_head", out_data, 8'hA1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("bp_in_ready_drain", 32'(in_ready), 1);
        idle(5);
        chk("bp_emit_count", 32'(emitted - e0), 4);
        chk("bp_drained", 32'(sb.size()), 0);

        // bubble collapse
        out_ready = 1'b0;
        send(8'h11);
        idle(1);
        send(8'h22);
        idle(3);
        chk("bub_occ", occupancy, 2);
        chk("bub_out_valid", 32'(out_valid), 1);
        chk("bub_head", out_data, 8'h11);
        chk("bub_in_ready", 32'(in_ready), 1);

        // flush at full occupancy
        send(8'h33);
        chk("fl_occ_before", occupancy, 3);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        #1;
        chk("fl_in_ready", 32'(in_ready), 0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ", occupancy, 0);
        chk("fl_out_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        e0 = emitted;
        idle(5);
        chk("fl_no_emit", 32'(emitted - e0), 0);

        // reset mid-operation
        out_ready = 1'b0;
        send(8'h44); send(8'h55);
        chk("mr_occ_before", occupancy, 2);
        rst = 1'b1;
        cyc();
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_out_data", out_data, 0);
        chk("mr_occ", occupancy, 0);
        chk("mr_stall", stall_cnt, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        e0 = emitted;
        send(8'h5A);
        idle(4);
        chk("mr_emit_count", 32'(emitted - e0), 1);
        chk("mr_drained", 32'(sb.size()), 0);

        // stall statistics
        rst = 1'b1; cyc(); rst = 1'b0;
        out_ready = 1'b0;
        send(8'h77);
        for (int k = 0; k < 10 && !out_valid; k++) cyc();
        chk("st_out_valid", 32'(out_valid), 1);
        chk("st_stall_zero", stall_cnt, 0);
        idle(10);
        chk("st_stall_10", stall_cnt, EXP_STALL);
        out_ready = 1'b1; flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("st_stall_after_flush", stall_cnt, EXP_STALL);
        chk("st_out_valid_after_flush", 32'(out_valid), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
